// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
//   Register bank that sits behind an SPI slave. The slave presents a register
//   address and a single-cycle write strobe. Read data is a zero-wait-state
//   combinational decode of the address.
//
//   Map: 0 ID (RO)  1 CTRL (RW)  2 CMD (WO, reads 0)  3 STATUS (W1C, [3:0])
//        4 IRQ_MASK (RW, [3:0])  5 EVT_CNT (RO)  6 SCRATCH (RW)  7 reserved
//
// Ports
//   clk            : system clock, rising edge
//   rstb           : synchronous active-low reset
//   ena            : global enable, 0 freezes all state
//   reg_addr       : register address from the SPI slave
//   reg_data_wr    : write data
//   reg_data_wr_dv : single-cycle write strobe
//   reg_data_rd    : read data for reg_addr
//   ctrl           : CTRL register contents
//   start_pulse    : one-cycle pulse after a CMD write with bit0 set
//   evt_in         : event lines, synchronous to clk
//   irq            : registered OR of STATUS & IRQ_MASK
// -----------------------------------------------------------------------------
module spi_reg_bank #(
  parameter int               ADDR_W   = 3,
  parameter int               REG_W    = 8,
  parameter logic [REG_W-1:0] ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_wr,
  input  logic              reg_data_wr_dv,
  output logic [REG_W-1:0]  reg_data_rd,
  output logic [REG_W-1:0]  ctrl,
  output logic              start_pulse,
  input  logic [3:0]        evt_in,
  output logic              irq
);

  localparam logic [2:0] A_ID       = 3'd0;
  localparam logic [2:0] A_CTRL     = 3'd1;
  localparam logic [2:0] A_CMD      = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_IRQ_MASK = 3'd4;
  localparam logic [2:0] A_EVT_CNT  = 3'd5;
  localparam logic [2:0] A_SCRATCH  = 3'd6;

  logic [REG_W-1:0] r_ctrl;
  logic [REG_W-1:0] r_scratch;
  logic [REG_W-1:0] r_evt_cnt;
  logic [3:0]       r_status;
  logic [3:0]       r_irq_mask;
  logic [3:0]       r_prev;
  logic             r_start_pulse;
  logic             r_irq;

  logic             w_addr_ok;
  logic [2:0]       w_sel;
  logic             w_wr;
  logic [3:0]       w_edge;
  logic [3:0]       w_w1c;
  logic             w_cnt_clr;

  // Any set address bit above [2:0] lands in the reserved space.
  if (ADDR_W > 3) begin : g_wide_addr
    assign w_addr_ok = (reg_addr[ADDR_W-1:3] == '0);
  end else begin : g_narrow_addr
    assign w_addr_ok = 1'b1;
  end

  assign w_sel     = reg_addr[2:0];
  assign w_wr      = ena & reg_data_wr_dv & w_addr_ok;
  assign w_edge    = evt_in & ~r_prev;
  assign w_w1c     = (w_wr && w_sel == A_STATUS) ? reg_data_wr[3:0] : 4'b0000;
  assign w_cnt_clr = w_wr && (w_sel == A_CMD) && reg_data_wr[1];

  assign ctrl = r_ctrl;
  assign irq  = r_irq;
  // Gated so the pulse is never visible on a frozen (ena=0) cycle.
  assign start_pulse = r_start_pulse & ena;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_ctrl        <= '0;
      r_scratch     <= '0;
      r_evt_cnt     <= '0;
      r_status      <= '0;
      r_irq_mask    <= '0;
      r_prev        <= '0;
      r_start_pulse <= 1'b0;
      r_irq         <= 1'b0;
    end else if (ena) begin
      r_prev        <= evt_in;
      r_start_pulse <= w_wr && (w_sel == A_CMD) && reg_data_wr[0];

      if (w_wr && w_sel == A_CTRL)     r_ctrl     <= reg_data_wr;
      if (w_wr && w_sel == A_SCRATCH)  r_scratch  <= reg_data_wr;
      if (w_wr && w_sel == A_IRQ_MASK) r_irq_mask <= reg_data_wr[3:0];

      // Clear first, then OR in new edges: a coincident set wins.
      r_status <= (r_status & ~w_w1c) | w_edge;

      // Clear outranks a same-cycle increment; counter saturates.
      if (w_cnt_clr)
        r_evt_cnt <= '0;
      else if (w_edge[0] && r_evt_cnt != '1)
        r_evt_cnt <= r_evt_cnt + REG_W'(1);

      r_irq <= |(r_status & r_irq_mask);
    end else begin
      r_start_pulse <= 1'b0;
    end
  end

  // NOTE: the default assignment up front keeps this decode free of latches
  // for any address that no case item covers.
  always_comb begin
    reg_data_rd = '0;
    if (w_addr_ok) begin
      case (w_sel)
        A_ID:       reg_data_rd = ID_VALUE;
        A_CTRL:     reg_data_rd = r_ctrl;
        A_STATUS:   reg_data_rd = REG_W'(r_status);
        A_IRQ_MASK: reg_data_rd = REG_W'(r_irq_mask);
        A_EVT_CNT:  reg_data_rd = r_evt_cnt;
        A_SCRATCH:  reg_data_rd = r_scratch;
        default:    reg_data_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank
//   Directed bench for spi_reg_bank. Inputs change 1 ns after each rising
//   edge; outputs are compared in that same window, away from the edge.
// -----------------------------------------------------------------------------
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena;
  logic [2:0] reg_addr;
  logic [7:0] reg_data_wr;
  logic       reg_data_wr_dv;
  logic [7:0] reg_data_rd;
  logic [7:0] ctrl;
  logic       start_pulse;
  logic [3:0] evt_in;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  spi_reg_bank dut (
    .clk            (clk),
    .rstb           (rstb),
    .ena            (ena),
    .reg_addr       (reg_addr),
    .reg_data_wr    (reg_data_wr),
    .reg_data_wr_dv (reg_data_wr_dv),
    .reg_data_rd    (reg_data_rd),
    .ctrl           (ctrl),
    .start_pulse    (start_pulse),
    .evt_in         (evt_in),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    reg_addr       = a;
    reg_data_wr    = d;
    reg_data_wr_dv = 1'b1;
    tick();
    reg_data_wr_dv = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_data_rd, exp);
  endtask

  task automatic evt_pulse(input logic [3:0] bits);
    evt_in = bits;
    tick();
    evt_in = 4'b0000;
    tick();
  endtask

  logic [7:0] reset_map [8] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    rstb = 1'b0; ena = 1'b1; reg_addr = 3'd0; reg_data_wr = 8'h00;
    reg_data_wr_dv = 1'b0; evt_in = 4'b0000;
    tick(); tick();
    rstb = 1'b1;

    // Reset state
    for (int i = 0; i < 8; i++) rd($sformatf("reset_rd%0d", i), 3'(i), reset_map[i]);
    check("reset_ctrl", ctrl, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'h00);
    check("reset_pulse", {7'd0, start_pulse}, 8'h00);

    // RW registers, RO and reserved writes
    wr(3'd1, 8'h3C);
    wr(3'd6, 8'h5A);
    rd("ctrl_rd", 3'd1, 8'h3C);
    rd("scratch_rd", 3'd6, 8'h5A);
    check("ctrl_port", ctrl, 8'h3C);
    wr(3'd0, 8'hFF);
    rd("id_ro", 3'd0, 8'hA5);
    wr(3'd7, 8'hFF);
    rd("rsvd_rd", 3'd7, 8'h00);
    wr(3'd5, 8'hFF);
    rd("evtcnt_ro", 3'd5, 8'h00);

    // CMD start pulse: single, then back-to-back
    wr(3'd2, 8'h01);
    check("pulse_hi", {7'd0, start_pulse}, 8'h01);
    tick();
    check("pulse_lo", {7'd0, start_pulse}, 8'h00);
    rd("cmd_rd0", 3'd2, 8'h00);
    wr(3'd2, 8'h01);
    check("b2b_pulse1", {7'd0, start_pulse}, 8'h01);
    wr(3'd2, 8'h01);
    check("b2b_pulse2", {7'd0, start_pulse}, 8'h01);
    tick();
    check("b2b_end", {7'd0, start_pulse}, 8'h00);
    wr(3'd2, 8'h02);
    check("no_pulse_bit1", {7'd0, start_pulse}, 8'h00);

    // IRQ path
    wr(3'd4, 8'hF4);
    rd("mask_rd", 3'd4, 8'h04);
    evt_in = 4'b0100;
    tick();
    evt_in = 4'b0000;
    rd("status_set", 3'd3, 8'h04);
    check("irq_lag", {7'd0, irq}, 8'h00);
    tick();
    check("irq_set", {7'd0, irq}, 8'h01);
    wr(3'd3, 8'h04);
    rd("status_clr", 3'd3, 8'h00);
    check("irq_still", {7'd0, irq}, 8'h01);
    tick();
    check("irq_clr", {7'd0, irq}, 8'h00);
    evt_in = 4'b0100;
    wr(3'd3, 8'h04);
    evt_in = 4'b0000;
    rd("set_wins", 3'd3, 8'h04);
    wr(3'd3, 8'h04);
    tick();

    // W1C leaves zero-written bits alone
    evt_pulse(4'b0011);
    rd("status_03", 3'd3, 8'h03);
    rd("evtcnt_1", 3'd5, 8'h01);
    wr(3'd3, 8'h01);
    rd("w1c_partial", 3'd3, 8'h02);
    wr(3'd3, 8'hF2);
    rd("w1c_all", 3'd3, 8'h00);

    // Event counter: count, saturate, clear-wins
    wr(3'd2, 8'h02);
    rd("cnt_clr", 3'd5, 8'h00);
    for (int i = 0; i < 10; i++) evt_pulse(4'b0001);
    rd("cnt_10", 3'd5, 8'h0A);
    for (int i = 0; i < 290; i++) evt_pulse(4'b0001);
    rd("cnt_sat", 3'd5, 8'hFF);
    evt_in = 4'b0001;
    wr(3'd2, 8'h02);
    evt_in = 4'b0000;
    rd("clr_wins", 3'd5, 8'h00);
    tick();
    wr(3'd3, 8'h0F);
    rd("status_clean", 3'd3, 8'h00);

    // Arm irq, then freeze with ena=0
    evt_pulse(4'b0100);
    check("irq_armed", {7'd0, irq}, 8'h01);
    wr(3'd2, 8'h01);
    ena = 1'b0;
    #1;
    check("pulse_gated", {7'd0, start_pulse}, 8'h00);
    wr(3'd1, 8'h11);
    wr(3'd3, 8'h04);
    wr(3'd6, 8'h99);
    wr(3'd2, 8'h03);
    evt_pulse(4'b1111);
    evt_pulse(4'b0001);
    check("frz_ctrl", ctrl, 8'h3C);
    check("frz_pulse", {7'd0, start_pulse}, 8'h00);
    check("frz_irq", {7'd0, irq}, 8'h01);
    rd("frz_status", 3'd3, 8'h04);
    rd("frz_cnt", 3'd5, 8'h00);
    rd("frz_scratch", 3'd6, 8'h5A);

    // Reset mid-operation with a pending pulse and a live irq
    ena = 1'b1;
    wr(3'd2, 8'h01);
    check("pre_rst_pulse", {7'd0, start_pulse}, 8'h01);
    check("pre_rst_irq", {7'd0, irq}, 8'h01);
    rstb = 1'b0;
    evt_in = 4'b0001;
    wr(3'd1, 8'hFF);
    check("rst_pulse", {7'd0, start_pulse}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_ctrl", ctrl, 8'h00);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_rd%0d", i), 3'(i), reset_map[i]);

    // First enabled cycle after reset sees a high evt_in as an edge
    rstb = 1'b1;
    tick();
    evt_in = 4'b0000;
    rd("post_rst_status", 3'd3, 8'h01);
    rd("post_rst_cnt", 3'd5, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter ADDR_W, default 3, register address width.
REQ-002 Parameter REG_W, default 8, register data width; all fields below assume REG_W=8.
REQ-003 Parameter ID_VALUE, default 8'hA5, read-only identification value.
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 rstb  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  global enable; 0 freezes all state.
REQ-007 reg_addr  input  ADDR_W  register address from the SPI slave.
REQ-008 reg_data_wr  input  REG_W  write data from the SPI slave.
REQ-009 reg_data_wr_dv  input  1  single-cycle write strobe.
REQ-010 reg_data_rd  output  REG_W  read data returned to the SPI slave.
REQ-011 ctrl  output  REG_W  CTRL register contents.
REQ-012 start_pulse  output  1  one-cycle command pulse.
REQ-013 evt_in  input  4  event lines, synchronous to clk.
REQ-014 irq  output  1  masked interrupt, registered.

Function
REQ-015 Register map: 0 ID (RO, reads ID_VALUE); 1 CTRL (RW); 2 CMD (WO, reads 0x00); 3 STATUS (W1C, bits[7:4] read 0); 4 IRQ_MASK (RW, bits[3:0] used, bits[7:4] read 0); 5 EVT_CNT (RO); 6 SCRATCH (RW); 7 reserved (reads 0x00, writes ignored).
REQ-016 A write occurs only on a cycle with reg_data_wr_dv=1 and ena=1; the target register shows the new value on reg_data_rd from the next cycle.
REQ-017 Writes to RO or reserved addresses shall change no state.
REQ-018 reg_data_rd shall be a combinational decode of reg_addr over current register state, with no wait states.
REQ-019 ctrl shall continuously equal CTRL.
REQ-020 A CMD write with bit0=1 shall assert start_pulse for exactly the following cycle; back-to-back CMD writes give back-to-back pulses.
REQ-021 A CMD write with bit1=1 shall clear EVT_CNT to 0x00.
REQ-022 Rising-edge detection: per-bit prev register of evt_in; edge = evt_in & ~prev; prev updates every enabled cycle.
REQ-023 An edge on evt_in[n] shall set STATUS[n] on the next clock; bits stay set until cleared.
REQ-024 A STATUS write clears each bit n where reg_data_wr[n]=1; bits written 0 are unchanged.
REQ-025 A set and a W1C on the same bit in the same cycle: set wins, bit ends at 1.
REQ-026 EVT_CNT shall increment on each evt_in[0] rising edge and saturate at 0xFF.
REQ-027 A CMD clear and an increment in the same cycle: clear wins, EVT_CNT ends at 0x00.
REQ-028 irq is registered: irq <= |(STATUS[3:0] & IRQ_MASK[3:0]), one cycle after the STATUS/IRQ_MASK update.
REQ-029 With ena=0, all registers, prev and irq shall hold; start_pulse shall be 0; writes and edges are ignored.
REQ-030 Address decode shall use reg_addr[2:0]; higher bits when ADDR_W>3 shall select reserved (read 0, write ignored).

Reset
REQ-031 While rstb=0 on a rising clk edge: CTRL, STATUS, IRQ_MASK, EVT_CNT, SCRATCH = 0x00; prev = 4'b0000; start_pulse = 0; irq = 0.
REQ-032 Reset shall take priority over ena and all writes.
REQ-033 Because prev resets to 0, an evt_in bit high on the first enabled post-reset cycle shall count as a rising edge.
REQ-034 Reset asserted mid-operation shall clear a pending start_pulse and irq at that edge.

Verification
REQ-035 After reset, read addrs 0..7 -> A5,00,00,00,00,00,00,00; ctrl=00, irq=0.
REQ-036 Write CTRL=0x3C and SCRATCH=0x5A, read back -> 3C/5A, ctrl=0x3C; write addr 0 with 0xFF -> ID still reads A5.
REQ-037 Write CMD=0x01 -> start_pulse high exactly one cycle; CMD reads 0x00.
REQ-038 Set IRQ_MASK=0x04, pulse evt_in[2] -> STATUS=0x04, irq=1 one cycle later; write STATUS=0x04 -> STATUS=0x00, irq=0 next cycle; W1C coincident with new edge -> STATUS stays 0x04.
REQ-039 Apply 300 evt_in[0] rising edges -> EVT_CNT=0xFF; CMD=0x02 coincident with an edge -> EVT_CNT=0x00.
REQ-040 With ena=0, write CTRL and toggle evt_in -> no register change and start_pulse=0; assert rstb mid-sequence -> all values return to REQ-031.
